up_counter: RTL and testbench
=============================

// Module: up_counter
// PURPOSE
//   Parameterised synchronous binary up-counter with enable, synchronous clear and parallel load.
//   Counts 0..MAX_COUNT, then wraps to 0 and flags the wrap with a one-cycle pulse and a sticky flag.
//   General-purpose timebase and event-count primitive; sits directly on the system clock domain.
// PARAMETERS
//   WIDTH      4              counter width in bits (>=1)
//   MAX_COUNT  (1<<WIDTH)-1   terminal value; must satisfy 0 < MAX_COUNT <= 2^WIDTH-1
// PORTS
//   clk       in   1      single clock; all state updates on rising edge
//   reset     in   1      asynchronous, active-low reset (0 = reset asserted)
//   en        in   1      count enable; increment when 1
//   clear     in   1      synchronous clear to 0
//   load      in   1      synchronous parallel load
//   load_val  in   WIDTH  value captured when load=1
//   counter   out  WIDTH  registered count value
//   tc        out  1      terminal count, combinational: counter==MAX_COUNT
//   wrap      out  1      registered one-cycle pulse: counter went MAX_COUNT->0 by increment
//   ovf       out  1      sticky overflow flag; set on wrap, held until clear or reset
// BEHAVIOUR
//   - Reset (reset==0, async, no clock needed): counter=0, wrap=0, ovf=0; tc=0 (follows counter).
//   - Deassertion of reset takes effect at next rising clk; first count occurs on that edge if en=1.
//   - Per-edge priority: clear > load > en > hold.
//   - clear=1: counter<=0, wrap<=0, ovf<=0 (regardless of load/en).
//   - load=1 (clear=0): counter<=min(load_val, MAX_COUNT); wrap<=0; ovf unchanged.
//   - en=1 (clear=0, load=0): counter<MAX_COUNT -> counter+1, wrap<=0;
//     counter==MAX_COUNT -> counter<=0, wrap<=1, ovf<=1.
//   - All idle (en=0): counter holds; wrap<=0; ovf holds.
//   - Latency: counter/wrap/ovf update one clock after the controlling inputs are sampled.
//   - wrap is high for exactly one cycle per wrap event; back-to-back wraps (MAX_COUNT=1 etc.)
//     produce wrap on each wrapping edge.
//   - Arithmetic is unsigned WIDTH-bit; no intermediate value above MAX_COUNT is ever visible.
//   - Reset asserted mid-count overrides everything immediately, including a pending wrap.
//   - Inputs assumed synchronous to clk; X on en/load/clear after reset is a bench error.
// CONFIGURATION
//   Macro UP_COUNTER_SATURATE_EN:
//   - Defined: counter saturates at MAX_COUNT; en=1 while counter==MAX_COUNT holds MAX_COUNT,
//     wrap stays 0 always, ovf<=1 (sticky, marks saturation hit). clear/load unchanged.
//   - Undefined (default): wrap-around behaviour as in BEHAVIOUR.
// TESTING
//   1. reset=0 for 2 cycles with en=1 -> counter=0, wrap=0, ovf=0, tc=0 throughout.
//   2. reset=1, en=1, 20 edges, WIDTH=4 -> counter 1..15, then 0 at edge 16 with wrap=1
//      for one cycle, ovf=1 thereafter, tc=1 exactly while counter=15.
//   3. load=1, load_val=9, then en=1 for 3 edges -> counter 9,10,11,12; en=0 -> holds 12.
//   4. clear=1 with load=1, en=1 at counter=12, ovf=1 -> counter=0, ovf=0 next edge.
//   5. reset pulled low asynchronously between edges at counter=7 -> counter=0 before next edge.
//   6. UP_COUNTER_SATURATE_EN, MAX_COUNT=10, en=1 for 14 edges -> counter stops at 10,
//      wrap never 1, ovf=1 from edge 11; load_val=13 loads 10.

Source files
------------

// File: rtl/up_counter.sv
// up_counter: parameterised binary up-counter with enable, synchronous clear,
// parallel load, terminal-count output, one-cycle wrap pulse and sticky overflow.
// Build option: define UP_COUNTER_SATURATE_EN to hold at MAX_COUNT instead of wrapping.
module up_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] counter_d;
    logic             wrap_d;
    logic             ovf_d;

    // Terminal count follows the registered count directly.
    assign tc = (counter == MAX_VAL);

    // Next-state selection: clear > load > en > hold.
    always_comb begin
        counter_d = counter;
        wrap_d    = 1'b0;
        ovf_d     = ovf;
        if (clear) begin
            counter_d = '0;
            ovf_d     = 1'b0;
        end else if (load) begin
            counter_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (counter == MAX_VAL) begin
`ifdef UP_COUNTER_SATURATE_EN
                counter_d = MAX_VAL;
                ovf_d     = 1'b1;
`else
                counter_d = '0;
                wrap_d    = 1'b1;
                ovf_d     = 1'b1;
`endif
            end else begin
                counter_d = counter + WIDTH'(1);
            end
        end
    end

    // State registers; reset clears everything immediately, including a pending wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter <= '0;
            wrap    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            counter <= counter_d;
            wrap    <= wrap_d;
            ovf     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_up_counter.sv
// Directed bench for up_counter: default 4-bit instance, a MAX_COUNT=10 instance
// and a MAX_COUNT=1 instance, all sharing one stimulus set.
`timescale 1ns/1ps
module tb_up_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       clear;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] cnt_a, cnt_b, cnt_c;
    logic       tc_a, tc_b, tc_c;
    logic       wrap_a, wrap_b, wrap_c;
    logic       ovf_a, ovf_b, ovf_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    up_counter #(.WIDTH(4)) dut_a (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load), .load_val(load_val),
        .counter(cnt_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a)
    );

    up_counter #(.WIDTH(4), .MAX_COUNT(10)) dut_b (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load), .load_val(load_val),
        .counter(cnt_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b)
    );

    up_counter #(.WIDTH(4), .MAX_COUNT(1)) dut_c (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load), .load_val(load_val),
        .counter(cnt_c), .tc(tc_c), .wrap(wrap_c), .ovf(ovf_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        en    = 1'b0;
        clear = 1'b0;
        load  = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; clear = 1'b0; load = 1'b0; load_val = 4'd0;
        #2;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (cnt_a !== 4'd0 || wrap_a !== 1'b0 || ovf_a !== 1'b0 || tc_a !== 1'b0) begin
                failures++;
                $display("FAIL reset cyc%0d: cnt=%0d wrap=%b ovf=%b tc=%b, want 0 0 0 0",
                         i, cnt_a, wrap_a, ovf_a, tc_a);
            end
        end
    endtask

    task automatic test_count_wrap();
        logic [3:0] exp_cnt;
        reset = 1'b1; en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            exp_cnt = 4'(i % 16);
            checks++;
            if (cnt_a !== exp_cnt || wrap_a !== (i == 16) || ovf_a !== (i >= 16)
                || tc_a !== (exp_cnt == 4'd15)) begin
                failures++;
                $display("FAIL count edge%0d: cnt=%0d wrap=%b ovf=%b tc=%b, want %0d %b %b %b",
                         i, cnt_a, wrap_a, ovf_a, tc_a, exp_cnt, (i == 16), (i >= 16),
                         (exp_cnt == 4'd15));
            end
        end
    endtask

    task automatic test_load();
        en = 1'b0; load = 1'b1; load_val = 4'd9;
        step();
        load = 1'b0;
        checks++;
        if (cnt_a !== 4'd9 || ovf_a !== 1'b1 || wrap_a !== 1'b0) begin
            failures++;
            $display("FAIL load9: cnt=%0d ovf=%b wrap=%b, want 9 1 0", cnt_a, ovf_a, wrap_a);
        end
        en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (cnt_a !== 4'(9 + i)) begin
                failures++;
                $display("FAIL load_count%0d: cnt=%0d, want %0d", i, cnt_a, 9 + i);
            end
        end
        en = 1'b0;
        step();
        step();
        checks++;
        if (cnt_a !== 4'd12 || wrap_a !== 1'b0) begin
            failures++;
            $display("FAIL hold: cnt=%0d wrap=%b, want 12 0", cnt_a, wrap_a);
        end
    endtask

    task automatic test_clear_priority();
        clear = 1'b1; load = 1'b1; en = 1'b1; load_val = 4'd5;
        step();
        clear = 1'b0; load = 1'b0; en = 1'b0;
        checks++;
        if (cnt_a !== 4'd0 || ovf_a !== 1'b0 || wrap_a !== 1'b0) begin
            failures++;
            $display("FAIL clear_prio: cnt=%0d ovf=%b wrap=%b, want 0 0 0", cnt_a, ovf_a, wrap_a);
        end
        load = 1'b1; en = 1'b1; load_val = 4'd3;
        step();
        load = 1'b0; en = 1'b0;
        checks++;
        if (cnt_a !== 4'd3) begin
            failures++;
            $display("FAIL load_over_en: cnt=%0d, want 3", cnt_a);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 7; i++) step();
        en = 1'b0;
        checks++;
        if (cnt_a !== 4'd7) begin
            failures++;
            $display("FAIL pre_async: cnt=%0d, want 7", cnt_a);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (cnt_a !== 4'd0 || tc_a !== 1'b0 || ovf_a !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: cnt=%0d tc=%b ovf=%b, want 0 0 0", cnt_a, tc_a, ovf_a);
        end
        step();
        reset = 1'b1;
    endtask

    task automatic test_max10();
        logic [3:0] exp_cnt;
        logic       exp_wrap;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step();
`ifdef UP_COUNTER_SATURATE_EN
            exp_cnt  = (i > 10) ? 4'd10 : 4'(i);
            exp_wrap = 1'b0;
`else
            exp_cnt  = 4'(i % 11);
            exp_wrap = (i == 11);
`endif
            checks++;
            if (cnt_b !== exp_cnt || wrap_b !== exp_wrap || ovf_b !== (i >= 11)
                || tc_b !== (exp_cnt == 4'd10)) begin
                failures++;
                $display("FAIL max10 edge%0d: cnt=%0d wrap=%b ovf=%b tc=%b, want %0d %b %b %b",
                         i, cnt_b, wrap_b, ovf_b, tc_b, exp_cnt, exp_wrap, (i >= 11),
                         (exp_cnt == 4'd10));
            end
        end
        en = 1'b0; load = 1'b1; load_val = 4'd13;
        step();
        load = 1'b0;
        checks++;
        if (cnt_b !== 4'd10 || tc_b !== 1'b1) begin
            failures++;
            $display("FAIL load_clamp: cnt=%0d tc=%b, want 10 1", cnt_b, tc_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_cnt;
        logic       exp_wrap;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
`ifdef UP_COUNTER_SATURATE_EN
            exp_cnt  = 4'd1;
            exp_wrap = 1'b0;
`else
            exp_cnt  = 4'(i % 2);
            exp_wrap = ((i % 2) == 0);
`endif
            checks++;
            if (cnt_c !== exp_cnt || wrap_c !== exp_wrap || ovf_c !== (i >= 2)) begin
                failures++;
                $display("FAIL b2b edge%0d: cnt=%0d wrap=%b ovf=%b, want %0d %b %b",
                         i, cnt_c, wrap_c, ovf_c, exp_cnt, exp_wrap, (i >= 2));
            end
        end
        en = 1'b0;
        step();
        checks++;
        if (wrap_c !== 1'b0 || ovf_c !== 1'b1) begin
            failures++;
            $display("FAIL b2b_idle: wrap=%b ovf=%b, want 0 1", wrap_c, ovf_c);
        end
    endtask

    initial begin
        test_reset();
        test_count_wrap();
        test_load();
        test_clear_priority();
        test_async_reset();
        test_max10();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
